ukf_div_arbiter: RTL and testbench

//  Shares one pipelined fixed-latency divider between the diagonal unit (req 0) and the four

---
 rtl/ukf_div_arbiter.sv | 115 +++++++++++
 tb/tb_ukf_div_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ukf_div_arbiter.sv
// ukf_div_arbiter: round-robin sharing of one fixed-latency divider; UKF_DIAG_PRIORITY_EN gives req[0] strict priority
module ukf_div_arbiter #(
  parameter int N_REQ   = 5,
  parameter int W       = 32,
  parameter int DIV_LAT = 8
) (
  input  logic               clock,
  input  logic               areset,
  input  logic               start,
  input  logic               finish,
  input  logic               stall,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   gnt,
  output logic               div_valid,
  output logic [W-1:0]       div_a,
  output logic [W-1:0]       div_b,
  output logic               div_ce,
  input  logic [W-1:0]       div_result,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               busy,
  output logic               done
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef UKF_DIAG_PRIORITY_EN
  localparam bit DIAG_PRIO = 1'b1;
`else
  localparam bit DIAG_PRIO = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d, elig;
  logic div_valid_q, div_valid_d, done_q, done_d, win_ok, fire, pipe_empty;
  logic [W-1:0] div_a_q, div_a_d, div_b_q, div_b_d, rsp_data_q, rsp_data_d;
  logic [IW-1:0] ptr_q, ptr_d, div_id_q, div_id_d, win, cand;
  logic [DIV_LAT-1:0] tv_q, tv_d;
  logic [IW-1:0] tid_q [DIV_LAT];
  logic [IW-1:0] tid_d [DIV_LAT];
  // With diag priority the pointer only ever rotates over 1..N_REQ-1.
  always_comb begin
    elig = req & ~gnt_q;
    win = '0;
    cand = '0;
    win_ok = DIAG_PRIO && elig[0];
    for (int k = 1; k <= N_REQ; k++) begin
      cand = DIAG_PRIO ? IW'((int'(ptr_q) + k - 1) % (N_REQ - 1) + 1) : IW'((int'(ptr_q) + k) % N_REQ);
      if (!win_ok && elig[cand]) begin
        win = cand;
        win_ok = 1'b1;
      end
    end
  end
  always_comb begin
    pipe_empty = ~|tv_q & ~div_valid_q;
    fire = (state_q == RUN) && !stall && win_ok;
    gnt_d = fire ? N_REQ'(1) << win : '0;
    ptr_d = (fire && !(DIAG_PRIO && win == '0)) ? win : ptr_q;
    div_valid_d = stall ? div_valid_q : fire;
    div_id_d = stall ? div_id_q : win;
    div_a_d = fire ? op_a[int'(win)*W +: W] : div_a_q;
    div_b_d = fire ? op_b[int'(win)*W +: W] : div_b_q;
    tv_d = stall ? tv_q : ((tv_q << 1) | DIV_LAT'(div_valid_q));
    tid_d = tid_q;
    if (!stall) begin
      tid_d[0] = div_id_q;
      for (int k = 1; k < DIV_LAT; k++) tid_d[k] = tid_q[k-1];
    end
    rsp_valid_d = (!stall && tv_q[DIV_LAT-1]) ? N_REQ'(1) << tid_q[DIV_LAT-1] : '0;
    rsp_data_d = (!stall && tv_q[DIV_LAT-1]) ? div_result : rsp_data_q;
    state_d = (state_q == IDLE && start) ? RUN :
              (state_q == RUN && finish) ? DRAIN :
              (state_q == DRAIN && pipe_empty) ? IDLE : state_q;
    done_d = (state_q == DRAIN) && pipe_empty;
  end
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      div_valid_q <= 1'b0;
      done_q <= 1'b0;
      div_a_q <= '0;
      div_b_q <= '0;
      rsp_data_q <= '0;
      ptr_q <= IW'(N_REQ - 1);
      div_id_q <= '0;
      tv_q <= '0;
      tid_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      div_valid_q <= div_valid_d;
      done_q <= done_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      rsp_data_q <= rsp_data_d;
      ptr_q <= ptr_d;
      div_id_q <= div_id_d;
      tv_q <= tv_d;
      tid_q <= tid_d;
    end
  end
  assign gnt = gnt_q;
  assign div_valid = div_valid_q;
  assign div_a = div_a_q;
  assign div_b = div_b_q;
  assign div_ce = ~stall;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
endmodule

// File: tb/tb_ukf_div_arbiter.sv
// tb_ukf_div_arbiter: randomized and directed checks of the divider arbiter against a queue-based model
`timescale 1ns/1ps
module tb_ukf_div_arbiter;
  localparam int N = 5, W = 32, L = 8;
  logic clock = 0, areset = 0, start = 0, finish = 0, stall = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] op_a = '0, op_b = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic div_valid, div_ce, busy, done;
  logic [W-1:0] div_a, div_b, div_result, rsp_data;
  int checks = 0, errors = 0, cyc = 0;
  logic [N-1:0] pend = '0;
  bit hold_all = 0;

  ukf_div_arbiter #(.N_REQ(N), .W(W), .DIV_LAT(L)) dut (
    .clock(clock), .areset(areset), .start(start), .finish(finish), .stall(stall),
    .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt), .div_valid(div_valid),
    .div_a(div_a), .div_b(div_b), .div_ce(div_ce), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .done(done));

  always #5 clock = ~clock;

  // divider: quotient appears L enabled cycles after div_valid
  logic [W-1:0] dq [L];
  always @(posedge clock or posedge areset)
    if (areset) for (int i = 0; i < L; i++) dq[i] <= '0;
    else if (div_ce) begin
      dq[0] <= (div_valid && div_b != 0) ? div_a / div_b : W'($urandom);
      for (int i = 1; i < L; i++) dq[i] <= dq[i-1];
    end
  assign div_result = dq[L-1];

  // reference: in-flight ops with countdown of unstalled edges until the response is visible
  typedef struct { int id; int left; logic [W-1:0] q; } ent_t;
  ent_t m_q[$];
  ent_t m_e;
  int m_mode, m_ptr, m_last, m_win, m_i;
  bit m_empty;
  logic [N-1:0] m_elig, exp_gnt, exp_rsp;
  logic [W-1:0] exp_data;
  logic exp_done, exp_busy;
  always @(posedge clock or posedge areset) begin
    if (areset) begin
      m_mode = 0; m_ptr = N - 1; m_last = -1; m_q.delete();
      exp_gnt = '0; exp_rsp = '0; exp_data = '0; exp_done = 0; exp_busy = 0;
    end else begin
      m_empty = m_q.size() == 0;
      exp_gnt = '0; exp_rsp = '0; exp_done = 0;
      if (!stall)
        for (int j = m_q.size() - 1; j >= 0; j--) begin
          m_q[j].left = m_q[j].left - 1;
          if (m_q[j].left == 0) begin
            exp_rsp[m_q[j].id] = 1'b1;
            exp_data = m_q[j].q;
            m_q.delete(j);
          end
        end
      m_win = -1;
      if (m_mode == 1 && !stall) begin
        for (int i = 0; i < N; i++) m_elig[i] = req[i] && i != m_last;
`ifdef UKF_DIAG_PRIORITY_EN
        if (m_elig[0]) m_win = 0;
        else for (int k = 1; k < N; k++) begin
          m_i = (m_ptr - 1 + k) % (N - 1) + 1;
          if (m_win < 0 && m_elig[m_i]) m_win = m_i;
        end
`else
        for (int k = 1; k <= N; k++) begin
          m_i = (m_ptr + k) % N;
          if (m_win < 0 && m_elig[m_i]) m_win = m_i;
        end
`endif
        if (m_win >= 0) begin
          exp_gnt[m_win] = 1'b1;
          m_e.id = m_win; m_e.left = L + 1;
          m_e.q = op_a[m_win*W +: W] / op_b[m_win*W +: W];
          m_q.push_back(m_e);
`ifdef UKF_DIAG_PRIORITY_EN
          if (m_win != 0) m_ptr = m_win;
`else
          m_ptr = m_win;
`endif
        end
      end
      m_last = m_win;
      if (m_mode == 0 && start) m_mode = 1;
      else if (m_mode == 1 && finish) m_mode = 2;
      else if (m_mode == 2 && m_empty) begin m_mode = 0; exp_done = 1; end
      exp_busy = m_mode != 0;
    end
  end

  task automatic tick();
    @(posedge clock); #1; cyc++;
    if (!hold_all) pend &= ~gnt;
    req = pend;
  endtask

  task automatic add_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!pend[i]) begin
      pend[i] = 1'b1;
      op_a[i*W +: W] = a;
      op_b[i*W +: W] = b;
    end
    req = pend;
  endtask

  task automatic do_reset();
    areset = 1; start = 0; finish = 0; stall = 0; pend = '0; req = '0; hold_all = 0;
    #2; areset = 0;
    tick();
  endtask

  task automatic test_reset();
    areset = 1; start = 0; finish = 0; stall = 0; pend = '0; req = '0;
    #1;
    checks++; if ({gnt, rsp_valid, div_valid, done, busy} !== '0) begin errors++; $display("FAIL reset_ctl got %b want 0", {gnt, rsp_valid, div_valid, done, busy}); end
    checks++; if ({div_a, div_b, rsp_data} !== '0) begin errors++; $display("FAIL reset_data got %h want 0", {div_a, div_b, rsp_data}); end
    @(posedge clock); #1; areset = 0;
    checks++; if (div_ce !== 1'b1) begin errors++; $display("FAIL reset_ce got %b want 1", div_ce); end
    finish = 1; add_req(1, 10, 2);
    tick(); finish = 0;
    tick();
    checks++; if ({gnt, busy} !== '0) begin errors++; $display("FAIL idle_hold got %b want 0", {gnt, busy}); end
  endtask

  task automatic test_single();
    do_reset();
    start = 1; finish = 1;
    tick(); start = 0; finish = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_wins busy got %b want 1", busy); end
    add_req(2, 100, 4);
    tick();
    checks++; if (gnt !== 5'b00100 || div_valid !== 1'b1) begin errors++; $display("FAIL single_gnt got %b/%b want 00100/1", gnt, div_valid); end
    for (int c = 0; c < 9; c++) begin
      tick();
      checks++; if ({gnt, rsp_valid, busy, done} !== {exp_gnt, exp_rsp, exp_busy, exp_done}) begin errors++; $display("FAIL single cyc %0d got %b want %b", cyc, {gnt, rsp_valid, busy, done}, {exp_gnt, exp_rsp, exp_busy, exp_done}); end
    end
    checks++; if (rsp_valid !== 5'b00100 || rsp_data !== 32'd25) begin errors++; $display("FAIL single_rsp got %b/%0d want 00100/25", rsp_valid, rsp_data); end
  endtask

  task automatic test_hold_all();
    int seq[8];
`ifdef UKF_DIAG_PRIORITY_EN
    seq = '{0, 1, 0, 2, 0, 3, 0, 4};
`else
    seq = '{0, 1, 2, 3, 4, 0, 1, 2};
`endif
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < N; i++) begin
      op_a[i*W +: W] = $urandom;
      op_b[i*W +: W] = $urandom_range(1, 5000);
    end
    hold_all = 1; pend = '1; req = '1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (gnt !== 5'(1) << seq[c]) begin errors++; $display("FAIL hold_order step %0d got %b want id %0d", c, gnt, seq[c]); end
    end
    hold_all = 0; pend = '0; req = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if ({gnt, rsp_valid, busy, done} !== {exp_gnt, exp_rsp, exp_busy, exp_done}) begin errors++; $display("FAIL hold cyc %0d got %b want %b", cyc, {gnt, rsp_valid, busy, done}, {exp_gnt, exp_rsp, exp_busy, exp_done}); end
      if (exp_rsp != 0) begin
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL hold_data cyc %0d got %0d want %0d", cyc, rsp_data, exp_data); end
      end
    end
  endtask

  task automatic test_stall();
    int gc[N], rc[N], nrsp;
    nrsp = 0;
    for (int i = 0; i < N; i++) begin gc[i] = -100; rc[i] = 0; end
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) add_req(i, $urandom, $urandom_range(1, 300));
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (gnt[i]) gc[i] = cyc;
    end
    stall = 1; #1;
    checks++; if (div_ce !== 1'b0) begin errors++; $display("FAIL stall_ce got %b want 0", div_ce); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if ({gnt, rsp_valid} !== '0) begin errors++; $display("FAIL stall_quiet cyc %0d got %b want 0", cyc, {gnt, rsp_valid}); end
    end
    stall = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++; if ({gnt, rsp_valid, busy, done} !== {exp_gnt, exp_rsp, exp_busy, exp_done}) begin errors++; $display("FAIL stall cyc %0d got %b want %b", cyc, {gnt, rsp_valid, busy, done}, {exp_gnt, exp_rsp, exp_busy, exp_done}); end
      if (exp_rsp != 0) begin
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL stall_data cyc %0d got %0d want %0d", cyc, rsp_data, exp_data); end
      end
      if (rsp_valid != 0) nrsp++;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) rc[i] = cyc;
    end
    checks++; if (nrsp !== 3) begin errors++; $display("FAIL stall_count got %0d want 3", nrsp); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rc[i] - gc[i] !== 14) begin errors++; $display("FAIL stall_delay id %0d got %0d want 14", i, rc[i] - gc[i]); end
    end
  endtask

  task automatic test_finish();
    int last_rsp, done_cyc, nrsp;
    last_rsp = -1; done_cyc = -1; nrsp = 0;
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 1; i < N; i++) add_req(i, $urandom, $urandom_range(1, 999));
    repeat (4) tick();
    finish = 1; tick(); finish = 0;
    add_req(0, 77, 7);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if ({gnt, rsp_valid, busy, done} !== {5'b0, exp_rsp, exp_busy, exp_done}) begin errors++; $display("FAIL drain cyc %0d got %b want %b", cyc, {gnt, rsp_valid, busy, done}, {5'b0, exp_rsp, exp_busy, exp_done}); end
      if (exp_rsp != 0) begin
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL drain_data cyc %0d got %0d want %0d", cyc, rsp_data, exp_data); end
      end
      if (rsp_valid != 0) begin last_rsp = cyc; nrsp++; end
      if (done) done_cyc = cyc;
    end
    checks++; if (nrsp !== 4) begin errors++; $display("FAIL drain_count got %0d want 4", nrsp); end
    checks++; if (done_cyc !== last_rsp + 1) begin errors++; $display("FAIL drain_done got cyc %0d want %0d", done_cyc, last_rsp + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    do_reset();
    start = 1; tick(); start = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) < 3) add_req(i, $urandom, $urandom_range(1, 1 << $urandom_range(1, 20)));
      stall = ($urandom_range(0, 9) == 0);
      tick();
      checks++; if ({gnt, rsp_valid, busy, done, div_ce} !== {exp_gnt, exp_rsp, exp_busy, exp_done, ~stall}) begin errors++; $display("FAIL random cyc %0d got %b want %b", cyc, {gnt, rsp_valid, busy, done, div_ce}, {exp_gnt, exp_rsp, exp_busy, exp_done, ~stall}); end
      if (exp_rsp != 0) begin
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL random_data cyc %0d got %0d want %0d", cyc, rsp_data, exp_data); end
      end
    end
    stall = 0; finish = 1; tick(); finish = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if ({gnt, rsp_valid, busy, done} !== {exp_gnt, exp_rsp, exp_busy, exp_done}) begin errors++; $display("FAIL rdrain cyc %0d got %b want %b", cyc, {gnt, rsp_valid, busy, done}, {exp_gnt, exp_rsp, exp_busy, exp_done}); end
      if (exp_rsp != 0) begin
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL rdrain_data cyc %0d got %0d want %0d", cyc, rsp_data, exp_data); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdrain_busy got %b want 0", busy); end
  endtask

  task automatic test_areset();
    int nrsp;
    nrsp = 0;
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) add_req(i, $urandom, $urandom_range(1, 77));
    repeat (4) tick();
    areset = 1; #1;
    checks++; if ({gnt, rsp_valid, div_valid, busy} !== '0) begin errors++; $display("FAIL areset_now got %b want 0", {gnt, rsp_valid, div_valid, busy}); end
    pend = '0; req = '0; #2; areset = 0;
    tick();
    start = 1; tick(); start = 0;
    add_req(3, 900, 30);
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++; if ({gnt, rsp_valid, busy, done} !== {exp_gnt, exp_rsp, exp_busy, exp_done}) begin errors++; $display("FAIL restart cyc %0d got %b want %b", cyc, {gnt, rsp_valid, busy, done}, {exp_gnt, exp_rsp, exp_busy, exp_done}); end
      if (rsp_valid != 0) begin
        nrsp++;
        checks++; if (rsp_valid !== 5'b01000 || rsp_data !== 32'd30) begin errors++; $display("FAIL restart_rsp got %b/%0d want 01000/30", rsp_valid, rsp_data); end
      end
    end
    checks++; if (nrsp !== 1) begin errors++; $display("FAIL restart_count got %0d want 1", nrsp); end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_hold_all();
    test_stall();
    test_finish();
    test_random();
    test_areset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
